// File: rtl/stream_pattern_matcher_if.sv
// Stream-side bundle of the pattern matcher: input words in, registered data and match report out.
// The matcher uses the slave view; the producer/consumer side uses the master view.
interface stream_pattern_matcher_if #(
  parameter int DATA_BYTES = 4,
  parameter int NUM_PATS   = 4,
  parameter int CNT_W      = 16,
  localparam int ID_W      = (NUM_PATS > 1) ? $clog2(NUM_PATS) : 1
);
  logic                    data_valid;
  logic [8*DATA_BYTES-1:0] data_in;
  logic [8*DATA_BYTES-1:0] data_out;
  logic                    data_out_vld;
  logic                    match;
  logic [ID_W-1:0]         match_id;
  logic [CNT_W-1:0]        match_offset;

  modport master (
    output data_valid, data_in,
    input  data_out, data_out_vld, match, match_id, match_offset
  );

  modport slave (
    input  data_valid, data_in,
    output data_out, data_out_vld, match, match_id, match_offset
  );
endinterface

// File: rtl/stream_pattern_matcher.sv
// Multi-pattern byte-stream matcher: finds any enabled pattern at every byte alignment,
// including matches spanning word boundaries, and reports slot and stream byte offset.
module stream_pattern_matcher #(
  parameter int DATA_BYTES = 4,
  parameter int PAT_BYTES  = 2,
  parameter int NUM_PATS   = 4,
  parameter int CNT_W      = 16,
  parameter bit STICKY     = 1'b1,
  localparam int ID_W      = (NUM_PATS > 1) ? $clog2(NUM_PATS) : 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   pat_we,
  input  logic [ID_W-1:0]        pat_sel,
  input  logic [8*PAT_BYTES-1:0] pat_wdata,
  input  logic [NUM_PATS-1:0]    pat_en,
  stream_pattern_matcher_if.slave s
);
  localparam int HIST_B = PAT_BYTES - 1;
  localparam int HIST_N = (HIST_B > 0) ? HIST_B : 1;
  localparam int WIN_B  = HIST_B + DATA_BYTES;
  localparam int SUM_W  = CNT_W + 16;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  typedef enum logic [1:0] {IDLE, ARMED, MATCHED} state_t;

  state_t                 state;
  logic [8*PAT_BYTES-1:0] pat_q [NUM_PATS];
  logic [7:0]             hist [HIST_N];
  logic [7:0]             win [WIN_B];
  logic [CNT_W-1:0]       byte_cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic [SUM_W-1:0]       cnt_sum;
  logic [SUM_W-1:0]       pos;
  logic                   eq;
  logic                   hit;
  logic [ID_W-1:0]        hit_id;
  logic [CNT_W-1:0]       hit_off;

  // Window = retained tail of previous words followed by the current word, oldest byte first.
  // NOTE: every always_comb output gets a default before any conditional write so no latch is inferred.
  always_comb begin
    win = '{default: '0};
    for (int j = 0; j < HIST_B; j++) win[j] = hist[j];
    for (int j = 0; j < DATA_BYTES; j++) win[HIST_B + j] = s.data_in[8*j +: 8];
  end

  // Scan from highest (slot, alignment) downwards so the lowest slot, then lowest k, wins.
  always_comb begin
    hit     = 1'b0;
    hit_id  = '0;
    hit_off = '0;
    eq      = 1'b0;
    pos     = '0;
    for (int i = NUM_PATS - 1; i >= 0; i--) begin
      for (int k = DATA_BYTES - 1; k >= 0; k--) begin
        pos = SUM_W'(byte_cnt) + SUM_W'(k);
        // A candidate must start at or after stream byte 0, never in pre-stream history.
        eq  = pat_en[i] && (pos >= SUM_W'(HIST_B));
        for (int b = 0; b < PAT_BYTES; b++) begin
          if (win[k + b] != pat_q[i][8*b +: 8]) eq = 1'b0;
        end
        if (eq) begin
          hit     = 1'b1;
          hit_id  = ID_W'(i);
          hit_off = CNT_W'(pos - SUM_W'(HIST_B));
        end
      end
    end
  end

  always_comb begin
    cnt_sum  = SUM_W'(byte_cnt) + SUM_W'(DATA_BYTES);
    cnt_next = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum);
  end

  // NOTE: pattern slots live in flops with an async reset because n_rst must wipe them too;
  // a RAM without reset would leave stale patterns live after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_PATS; i++) pat_q[i] <= '0;
    end else if (pat_we) begin
      pat_q[pat_sel] <= pat_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      hist           <= '{default: '0};
      s.data_out     <= '0;
      s.data_out_vld <= 1'b0;
      s.match        <= 1'b0;
      s.match_id     <= '0;
      s.match_offset <= '0;
    end else if (clear) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      hist           <= '{default: '0};
      s.data_out     <= '0;
      s.data_out_vld <= 1'b0;
      s.match        <= 1'b0;
      s.match_id     <= '0;
      s.match_offset <= '0;
    end else begin
      s.data_out_vld <= s.data_valid;
      if (!STICKY) s.match <= 1'b0;
      if (s.data_valid) begin
        s.data_out <= s.data_in;
        byte_cnt   <= cnt_next;
        for (int j = 0; j < HIST_B; j++) hist[j] <= win[DATA_BYTES + j];
        case (state)
          IDLE, ARMED: begin
            state <= ARMED;
            if (hit) begin
              s.match        <= 1'b1;
              s.match_id     <= hit_id;
              s.match_offset <= hit_off;
              if (STICKY) state <= MATCHED;
            end
          end
          default: state <= MATCHED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stream_pattern_matcher.sv
// Directed bench: a sticky matcher (CNT_W=16) and a pulsing matcher (CNT_W=4, saturation)
// driven with hand-computed words and expected match reports.
module tb_stream_pattern_matcher;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic        a_clear, a_we;
  logic [1:0]  a_sel;
  logic [15:0] a_wdata;
  logic [3:0]  a_en;
  logic        b_clear, b_we;
  logic [1:0]  b_sel;
  logic [15:0] b_wdata;
  logic [3:0]  b_en;

  stream_pattern_matcher_if #(.DATA_BYTES(4), .NUM_PATS(4), .CNT_W(16)) sif ();
  stream_pattern_matcher_if #(.DATA_BYTES(4), .NUM_PATS(4), .CNT_W(4))  pif ();

  stream_pattern_matcher #(.DATA_BYTES(4), .PAT_BYTES(2), .NUM_PATS(4), .CNT_W(16), .STICKY(1'b1)) u_sticky (
    .clk(clk), .n_rst(n_rst), .clear(a_clear), .pat_we(a_we), .pat_sel(a_sel),
    .pat_wdata(a_wdata), .pat_en(a_en), .s(sif.slave)
  );

  stream_pattern_matcher #(.DATA_BYTES(4), .PAT_BYTES(2), .NUM_PATS(4), .CNT_W(4), .STICKY(1'b0)) u_pulse (
    .clk(clk), .n_rst(n_rst), .clear(b_clear), .pat_we(b_we), .pat_sel(b_sel),
    .pat_wdata(b_wdata), .pat_en(b_en), .s(pif.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [1:0] sel, input logic [15:0] p);
    a_we = 1'b1; a_sel = sel; a_wdata = p;
    tick();
    a_we = 1'b0;
  endtask

  task automatic a_send(input logic [31:0] w);
    sif.data_valid = 1'b1; sif.data_in = w;
    tick();
    sif.data_valid = 1'b0;
  endtask

  task automatic a_clr();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
  endtask

  task automatic b_send(input logic [31:0] w);
    pif.data_valid = 1'b1; pif.data_in = w;
    tick();
    pif.data_valid = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    a_clear = 1'b0; a_we = 1'b0; a_sel = '0; a_wdata = '0; a_en = '0;
    b_clear = 1'b0; b_we = 1'b0; b_sel = '0; b_wdata = '0; b_en = '0;
    sif.data_valid = 1'b0; sif.data_in = '0;
    pif.data_valid = 1'b0; pif.data_in = '0;
    #12;
    check("rst_match",   {63'd0, sif.match}, 64'd0);
    check("rst_vld",     {63'd0, sif.data_out_vld}, 64'd0);
    check("rst_dout",    {32'd0, sif.data_out}, 64'd0);
    check("rst_offset",  {48'd0, sif.match_offset}, 64'd0);
    n_rst = 1'b1;
    tick();

    // Pattern straddling the word boundary: bytes 33 | 44.
    a_write(2'd0, 16'h4433);
    a_en = 4'b0001;
    a_send(32'h33221100);
    check("span_w1_match", {63'd0, sif.match}, 64'd0);
    check("span_w1_vld",   {63'd0, sif.data_out_vld}, 64'd1);
    check("span_w1_dout",  {32'd0, sif.data_out}, 64'h33221100);
    a_send(32'h77665544);
    check("span_match",  {63'd0, sif.match}, 64'd1);
    check("span_id",     {62'd0, sif.match_id}, 64'd0);
    check("span_offset", {48'd0, sif.match_offset}, 64'd3);
    a_send(32'h00443300);
    check("sticky_frozen_offset", {48'd0, sif.match_offset}, 64'd3);
    tick();
    check("idle_vld",  {63'd0, sif.data_out_vld}, 64'd0);
    check("idle_dout", {32'd0, sif.data_out}, 64'h00443300);

    // Priority: slot1 beats slot2 even though slot2 hits at a lower alignment.
    a_clr();
    check("clr_match", {63'd0, sif.match}, 64'd0);
    check("clr_dout",  {32'd0, sif.data_out}, 64'd0);
    a_write(2'd1, 16'h2211);
    a_write(2'd2, 16'h1100);
    a_en = 4'b0110;
    a_send(32'h33221100);
    check("prio_match",  {63'd0, sif.match}, 64'd1);
    check("prio_id",     {62'd0, sif.match_id}, 64'd1);
    check("prio_offset", {48'd0, sif.match_offset}, 64'd1);
    a_clr();
    a_en = 4'b0100;
    a_send(32'h33221100);
    check("prio2_id",     {62'd0, sif.match_id}, 64'd2);
    check("prio2_offset", {48'd0, sif.match_offset}, 64'd0);

    // All-zero pattern must not hit the zeroed pre-stream history.
    a_write(2'd0, 16'h0000);
    a_en = 4'b0001;
    a_clr();
    a_send(32'hFFFF00FF);
    check("zero_w1_match", {63'd0, sif.match}, 64'd0);
    a_send(32'h000000FF);
    check("zero_match",  {63'd0, sif.match}, 64'd1);
    check("zero_offset", {48'd0, sif.match_offset}, 64'd5);

    // Clear beats data_valid: the word is dropped and counting restarts.
    a_clear = 1'b1; sif.data_valid = 1'b1; sif.data_in = 32'h12345678;
    tick();
    a_clear = 1'b0; sif.data_valid = 1'b0;
    check("clrv_match", {63'd0, sif.match}, 64'd0);
    check("clrv_vld",   {63'd0, sif.data_out_vld}, 64'd0);
    check("clrv_dout",  {32'd0, sif.data_out}, 64'd0);
    a_write(2'd0, 16'h4433);
    tick();
    check("hold_match", {63'd0, sif.match}, 64'd0);
    a_send(32'h33221100);
    check("restart_w1_match", {63'd0, sif.match}, 64'd0);
    a_send(32'h77665544);
    check("restart_match",  {63'd0, sif.match}, 64'd1);
    check("restart_offset", {48'd0, sif.match_offset}, 64'd3);

    // Pulsing matcher with a 4-bit counter that saturates at 15.
    b_we = 1'b1; b_sel = 2'd0; b_wdata = 16'h0201;
    tick();
    b_we = 1'b0;
    b_en = 4'b0001;
    b_send(32'h04030201);
    check("pulse1_match",  {63'd0, pif.match}, 64'd1);
    check("pulse1_offset", {60'd0, pif.match_offset}, 64'd0);
    b_send(32'h04030201);
    check("pulse2_match",  {63'd0, pif.match}, 64'd1);
    check("pulse2_offset", {60'd0, pif.match_offset}, 64'd4);
    b_send(32'h04030201);
    check("pulse3_match",  {63'd0, pif.match}, 64'd1);
    check("pulse3_offset", {60'd0, pif.match_offset}, 64'd8);
    tick();
    check("pulse_gap_match",  {63'd0, pif.match}, 64'd0);
    check("pulse_gap_offset", {60'd0, pif.match_offset}, 64'd8);
    b_send(32'h04030201);
    check("pulse4_offset", {60'd0, pif.match_offset}, 64'd12);
    b_send(32'h04030201);
    check("sat_match",  {63'd0, pif.match}, 64'd1);
    check("sat_offset", {60'd0, pif.match_offset}, 64'd15);
    // A pattern write in the same cycle as a word still compares against the old pattern.
    b_we = 1'b1; b_sel = 2'd0; b_wdata = 16'hAAAA;
    pif.data_valid = 1'b1; pif.data_in = 32'h04030201;
    tick();
    b_we = 1'b0; pif.data_valid = 1'b0;
    check("wr_old_match", {63'd0, pif.match}, 64'd1);
    b_send(32'h04030201);
    check("wr_new_match",  {63'd0, pif.match}, 64'd0);
    check("wr_new_offset", {60'd0, pif.match_offset}, 64'd15);

    // Async reset between edges clears everything, patterns included.
    check("pre_rst_match", {63'd0, sif.match}, 64'd1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("arst_match",  {63'd0, sif.match}, 64'd0);
    check("arst_dout",   {32'd0, sif.data_out}, 64'd0);
    check("arst_offset", {48'd0, sif.match_offset}, 64'd0);
    check("arst_vld",    {63'd0, pif.data_out_vld}, 64'd0);
    #2;
    n_rst = 1'b1;
    tick();
    a_send(32'h0000FFFF);
    check("post_rst_match",  {63'd0, sif.match}, 64'd1);
    check("post_rst_offset", {48'd0, sif.match_offset}, 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
